// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard tracking in-flight multi-cycle writes; stalls ID on RAW/WAW/capacity hazards.
// Hazard and alloc outputs are combinational from registered entry state; ex_ready low holds ID without allocating.
module hazard_scoreboard #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = $clog2(NUM_ENTRIES),
  parameter bit MEM_FWD     = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            id_instr,
  input  logic                   id_valid,
  input  logic                   id_flush,
  input  logic                   ex_ready,
  input  logic                   cmp_valid,
  input  logic [TAG_W-1:0]       cmp_tag,
  output logic                   bubble,
  output logic                   alloc,
  output logic [TAG_W-1:0]       alloc_tag,
  output logic [NUM_ENTRIES-1:0] busy,
  output logic                   full,
  output logic [CNT_W-1:0]       stall_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [4:0]             rd_q  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] cls_q;
  logic [CNT_W-1:0]       stall_q, stall_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [6:0] funct7;
  logic       use_rs1, use_rs2, is_store, is_load, producer;
  logic       raw, waw, cap, issue;
  logic [NUM_ENTRIES-1:0] cmp_hit;
  logic [TAG_W-1:0]       free_tag;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign funct7 = id_instr[31:25];

  assign is_store = (opcode == OP_STORE);
  assign is_load  = (opcode == OP_LOAD);
  assign use_rs1  = (opcode == OP_JALR) || is_load || (opcode == OP_IMM) ||
                    is_store || (opcode == OP_BR) || (opcode == OP_REG);
  assign use_rs2  = is_store || (opcode == OP_BR) || (opcode == OP_REG);
  // class bit: 1 = load, 0 = M-extension op
  assign producer = (rd != 5'd0) &&
                    (is_load || ((opcode == OP_REG) && (funct7 == 7'b0000001)));

  always_comb begin
    raw     = 1'b0;
    waw     = 1'b0;
    cmp_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      logic live, m1, m2;
      cmp_hit[i] = cmp_valid && (cmp_tag == TAG_W'(i));
      live = valid_q[i] && !cmp_hit[i];
      m1   = use_rs1 && (rd_q[i] == rs1);
      // loads feeding store data are covered by the memory forwarding path
      m2   = use_rs2 && (rd_q[i] == rs2) && !(MEM_FWD && is_store && cls_q[i]);
      raw  = raw || (live && (m1 || m2));
      waw  = waw || (live && producer && (rd_q[i] == rd));
    end
  end

  always_comb begin
    free_tag = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_tag = TAG_W'(i);
    end
  end

  assign full      = &valid_q;
  assign busy      = valid_q;
  assign cap       = producer && full;
  assign bubble    = id_valid && !id_flush && (raw || waw || cap);
  assign issue     = id_valid && !id_flush && !bubble && ex_ready;
  assign alloc     = issue && producer;
  assign alloc_tag = alloc ? free_tag : '0;
  assign stall_count = stall_q;

  always_comb begin
    valid_d = valid_q & ~cmp_hit;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc && (free_tag == TAG_W'(i))) valid_d[i] = 1'b1;
    end
    stall_d = stall_q;
    if (bubble && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc && (free_tag == TAG_W'(i))) begin
        rd_q[i]  <= rd;
        cls_q[i] <= is_load;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a MEM_FWD=0, CNT_W=4 instance on shared stimulus.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid, id_flush, ex_ready, cmp_valid;
  logic [1:0]  cmp_tag;

  logic        bubble, alloc, full;
  logic [1:0]  alloc_tag;
  logic [3:0]  busy;
  logic [31:0] stall_count;

  logic        bubble_b, alloc_b, full_b;
  logic [1:0]  alloc_tag_b;
  logic [3:0]  busy_b;
  logic [3:0]  stall_count_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .id_flush(id_flush), .ex_ready(ex_ready), .cmp_valid(cmp_valid),
    .cmp_tag(cmp_tag), .bubble(bubble), .alloc(alloc), .alloc_tag(alloc_tag),
    .busy(busy), .full(full), .stall_count(stall_count)
  );

  hazard_scoreboard #(.MEM_FWD(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .id_flush(id_flush), .ex_ready(ex_ready), .cmp_valid(cmp_valid),
    .cmp_tag(cmp_tag), .bubble(bubble_b), .alloc(alloc_b), .alloc_tag(alloc_tag_b),
    .busy(busy_b), .full(full_b), .stall_count(stall_count_b)
  );

  function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] st(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'h00, rs2, rs1, 3'b010, 5'h00, 7'b0100011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    id_valid = 1'b1;
    id_instr = instr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; id_flush = 1'b0;
    ex_ready = 1'b1; cmp_valid = 1'b0; cmp_tag = 2'd0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_stall", stall_count, 32'h0);
    chk("rst_stall_b", 32'(stall_count_b), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_alloc", 32'(alloc), 32'h0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'h0);

    // load-use
    drive(ld(5'd5, 5'd1));
    chk("lu_alloc", 32'(alloc), 32'h1);
    chk("lu_alloc_tag", 32'(alloc_tag), 32'h0);
    chk("lu_no_bubble", 32'(bubble), 32'h0);
    cyc();
    drive(add(5'd6, 5'd5, 5'd1));
    chk("lu_busy", 32'(busy), 32'h1);
    chk("lu_bubble1", 32'(bubble), 32'h1);
    cyc();
    chk("lu_bubble2", 32'(bubble), 32'h1);
    cyc();
    cmp_valid = 1'b1; cmp_tag = 2'd0;
    #1;
    chk("lu_bypass_bubble", 32'(bubble), 32'h0);
    chk("lu_bypass_alloc", 32'(alloc), 32'h0);
    chk("lu_stall_count", stall_count, 32'd2);
    cyc();
    cmp_valid = 1'b0; id_valid = 1'b0;
    #1;
    chk("lu_busy_clear", 32'(busy), 32'h0);
    chk("lu_stall_hold", stall_count, 32'd2);

    // store exemption
    drive(ld(5'd5, 5'd1));
    cyc();
    drive(st(5'd5, 5'd2));
    chk("st_rs2_fwd", 32'(bubble), 32'h0);
    chk("st_rs2_nofwd", 32'(bubble_b), 32'h1);
    drive(st(5'd2, 5'd5));
    chk("st_rs1_fwd", 32'(bubble), 32'h1);
    chk("st_rs1_nofwd", 32'(bubble_b), 32'h1);
    id_valid = 1'b0; cmp_valid = 1'b1; cmp_tag = 2'd0;
    cyc();
    cmp_valid = 1'b0;
    #1;
    chk("st_busy_clear", 32'(busy), 32'h0);

    // capacity and tags
    for (int i = 0; i < 4; i++) begin
      drive(ld(5'(i + 1), 5'd0));
      chk("cap_alloc", 32'(alloc), 32'h1);
      chk("cap_alloc_tag", 32'(alloc_tag), 32'(i));
      cyc();
    end
    chk("cap_busy", 32'(busy), 32'hf);
    chk("cap_full", 32'(full), 32'h1);
    drive(ld(5'd8, 5'd0));
    chk("cap_bubble", 32'(bubble), 32'h1);
    chk("cap_no_alloc", 32'(alloc), 32'h0);
    cmp_valid = 1'b1; cmp_tag = 2'd2;
    #1;
    chk("cap_cmp_bubble", 32'(bubble), 32'h1);
    chk("cap_cmp_no_alloc", 32'(alloc), 32'h0);
    cyc();
    cmp_valid = 1'b0;
    #1;
    chk("cap_busy_hole", 32'(busy), 32'hb);
    chk("cap_reissue_bubble", 32'(bubble), 32'h0);
    chk("cap_reissue_alloc", 32'(alloc), 32'h1);
    chk("cap_reissue_tag", 32'(alloc_tag), 32'h2);
    cyc();
    id_valid = 1'b0;
    #1;
    chk("cap_refull", 32'(full), 32'h1);
    for (int t = 0; t < 4; t++) begin
      cmp_valid = 1'b1; cmp_tag = 2'(t);
      cyc();
    end
    cmp_valid = 1'b0;
    #1;
    chk("cap_drain", 32'(busy), 32'h0);

    // WAW with simultaneous completion
    drive(mul(5'd7, 5'd1, 5'd2));
    chk("waw_first_alloc", 32'(alloc_tag), 32'h0);
    cyc();
    chk("waw_bubble", 32'(bubble), 32'h1);
    cmp_valid = 1'b1; cmp_tag = 2'd0;
    #1;
    chk("waw_cmp_bubble", 32'(bubble), 32'h0);
    chk("waw_cmp_alloc", 32'(alloc), 32'h1);
    chk("waw_cmp_tag", 32'(alloc_tag), 32'h1);
    cyc();
    cmp_valid = 1'b0; id_valid = 1'b0;
    #1;
    chk("waw_busy", 32'(busy), 32'h2);
    cmp_valid = 1'b1; cmp_tag = 2'd1;
    cyc();
    cmp_valid = 1'b0;

    // x0 destination is never tracked
    drive(ld(5'd0, 5'd1));
    chk("x0_alloc", 32'(alloc), 32'h0);
    chk("x0_bubble", 32'(bubble), 32'h0);
    cyc();
    chk("x0_busy", 32'(busy), 32'h0);

    // flush
    drive(ld(5'd5, 5'd1));
    cyc();
    drive(add(5'd6, 5'd5, 5'd1));
    chk("fl_hazard", 32'(bubble), 32'h1);
    id_flush = 1'b1;
    #1;
    chk("fl_bubble", 32'(bubble), 32'h0);
    chk("fl_alloc", 32'(alloc), 32'h0);
    drive(ld(5'd9, 5'd1));
    chk("fl_prod_alloc", 32'(alloc), 32'h0);
    cyc();
    id_flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'h1);

    // reset with three entries busy
    drive(ld(5'd10, 5'd1));
    chk("rs_tag1", 32'(alloc_tag), 32'h1);
    cyc();
    drive(ld(5'd11, 5'd1));
    chk("rs_tag2", 32'(alloc_tag), 32'h2);
    cyc();
    id_valid = 1'b0;
    #1;
    chk("rs_busy3", 32'(busy), 32'h7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rs_busy0", 32'(busy), 32'h0);
    chk("rs_full0", 32'(full), 32'h0);
    chk("rs_stall0", stall_count, 32'h0);
    cmp_valid = 1'b1; cmp_tag = 2'd1;
    drive(ld(5'd5, 5'd1));
    chk("rs_new_tag", 32'(alloc_tag), 32'h0);
    cyc();
    cmp_valid = 1'b0;
    drive(add(5'd6, 5'd5, 5'd1));
    chk("rs_stale_cmp", 32'(busy), 32'h1);

    // counter saturation over 20 stall cycles
    repeat (20) cyc();
    chk("sat_stall_32", stall_count, 32'd20);
    chk("sat_stall_4", 32'(stall_count_b), 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the single-load-use hazard check: a scoreboard that tracks up to NUM_ENTRIES in-flight multi-cycle register writes and stalls the decode stage on RAW, WAW or capacity hazards. Multi-cycle writers are loads and M-extension ops. The block sits between ID and EX. It decodes source usage of the ID instruction, allocates a tagged entry when a multi-cycle producer issues, and frees the entry when the producer's completion tag returns. It also keeps a saturating count of stall cycles for performance analysis.

## Interface
- NUM_ENTRIES, 4: number of outstanding multi-cycle writes tracked; minimum 2.
- TAG_W, $clog2(NUM_ENTRIES): entry tag width.
- MEM_FWD, 1: when 1, a store whose rs2 matches a pending load is not stalled, because the memory forwarding path covers it.
- CNT_W, 32: stall counter width.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_instr  in  32  instruction in ID (rv32i_word).
- id_valid  in  1  id_instr is a real instruction.
- id_flush  in  1  ID instruction is being squashed this cycle.
- ex_ready  in  1  EX accepts an instruction this cycle.
- cmp_valid  in  1  a tracked producer completes this cycle.
- cmp_tag  in  TAG_W  tag of the completing producer.
- bubble  out  1  stall ID/IF and inject a NOP into EX.
- alloc  out  1  an entry is allocated this cycle.
- alloc_tag  out  TAG_W  tag of the allocated entry; valid only while alloc=1.
- busy  out  NUM_ENTRIES  per-entry valid vector (registered).
- full  out  1  all entries valid (registered).
- stall_count  out  CNT_W  saturating count of bubble cycles.

## Operation
- Decode uses the rv32i_opcode view of id_instr[6:0]. Fields: rs1=[19:15], rs2=[24:20], rd=[11:7].
- Source usage:
  - lui, auipc, jal: no sources.
  - jalr, load, imm: rs1 only.
  - store, br, reg: rs1 and rs2.
  - Any other opcode: no sources.
- Producer classification:
  - op_load with rd!=0: class LOAD.
  - op_reg with funct7=7'b0000001 and rd!=0: class MUL.
  - Everything else is not tracked.
- Each entry stores valid, rd[4:0] and class[0:0].
- An entry is "live" when it is valid and not completing this cycle. Completing means cmp_valid=1 and cmp_tag equals the entry index.
- RAW hazard: a live entry whose rd equals a used rs1, or a used rs2.
- Store exemption: with MEM_FWD=1 and the ID opcode op_store, a match on rs2 only, against a LOAD entry, is not a hazard.
- WAW hazard: the ID instruction is a producer and a live entry has the same rd.
- Capacity hazard: the ID instruction is a producer and full=1. Entries completing this cycle still count toward full.
- bubble = id_valid & ~id_flush & (RAW | WAW | capacity). The value is combinational from the current entry state.
- issue = id_valid & ~id_flush & ~bubble & ex_ready.
- alloc = issue & producer. alloc_tag is the lowest-index invalid entry.
- On the clock edge the completing entry is cleared and the allocated entry is set. Both may happen in the same cycle, always to different entries.
- A completion naming an invalid entry is ignored, with no state change.
- stall_count increments when bubble=1 and holds at its maximum value of all ones.

## Timing
- Reset values:
  - All entries invalid.
  - busy=0, full=0, stall_count=0.
  - bubble=0, alloc=0 and alloc_tag=0 whenever id_valid=0.
- Allocation latency:
  - An entry allocated at edge N is visible in busy/full from cycle N+1.
  - It can cause a hazard from cycle N+1.
- Completion bypass:
  - A matching consumer stalls zero cycles in the cycle its producer's cmp arrives.
  - busy clears at the following edge.
- ex_ready=0 without a hazard gives no bubble and no allocation. The external pipeline holds ID.
- id_flush=1 forces bubble=0 and alloc=0. Existing entries are unaffected.
- rst mid-operation clears all entries on the next edge. Completions that arrive later are ignored as invalid tags.

## Test plan
- Load-use case:
  - Stimulus: issue lw x5 (tag 0), then present add x6,x5,x1 next cycle with no cmp.
  - Required: bubble=1 each cycle until cmp_valid=1 with cmp_tag=0. In that cycle bubble=0, and in the next cycle busy=0. stall_count equals the stall cycles.
- Store exemption:
  - Stimulus: pending lw x5, then sw x5,0(x2).
  - Required: bubble=0 with MEM_FWD=1 and bubble=1 with MEM_FWD=0. sw x2,0(x5), where x5 is in rs1, gives bubble=1 in both cases.
- Capacity and tags:
  - Stimulus: issue 4 independent loads to x1..x4.
  - Required: tags 0,1,2,3, then full=1. A 5th load gives bubble=1.
  - Stimulus: complete tag 2.
  - Required: the 5th load stalls in the cmp cycle, then issues with alloc_tag=2.
- WAW and simultaneous events:
  - Stimulus: mul x7 pending (tag 0) and mul x7 in ID.
  - Required: bubble=1.
  - Stimulus: cmp tag 0 in the same cycle.
  - Required: bubble=0, alloc=1, alloc_tag=1, and busy becomes 2'b10 in the low bits.
- x0, flush and reset:
  - Stimulus: lw x0 in ID.
  - Required: no allocation.
  - Stimulus: id_flush=1 with a hazard present.
  - Required: bubble=0, alloc=0.
  - Stimulus: rst asserted with 3 entries busy.
  - Required: busy=0 next cycle and stall_count=0. A stale cmp on tag 1 is ignored.
- Counter saturation:
  - Stimulus: CNT_W=4 with 20 consecutive stall cycles.
  - Required: stall_count stops at 15.
